// File: rtl/safe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : safe_pkg
// Brief   : Shared state encoding and parameter defaults for the safe lock.
// Revision: 1.0
// ============================================================================
package safe_pkg;

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    localparam int unsigned c_OPEN_CYCLES_DEFAULT = 50_000_000;
    localparam int unsigned c_LOCK_CYCLES_DEFAULT = 500_000_000;
    localparam int unsigned c_MAX_FAILS_DEFAULT   = 3;

endpackage
`default_nettype wire

// File: rtl/edge_rise.sv
`default_nettype none
// ============================================================================
// Module  : edge_rise
// Brief   : Rising-edge detector; history resets high so a held input is not an edge.
// Revision: 1.0
// ============================================================================
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= d;
        end
    end

    assign pulse = d & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/safe_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : safe_lock_ctrl
// Brief   : Code-entry lock FSM with open hold timer and failure lockout.
// Revision: 1.0
// ============================================================================
module safe_lock_ctrl
    import safe_pkg::*;
#(
    parameter int unsigned OPEN_CYCLES = c_OPEN_CYCLES_DEFAULT,
    parameter int unsigned LOCK_CYCLES = c_LOCK_CYCLES_DEFAULT,
    parameter int unsigned MAX_FAILS   = c_MAX_FAILS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter,
    input  logic       code_ok,
    input  logic       door_closed,
    output logic       unlock,
    output logic       alarm,
    output logic [2:0] fail_cnt
);

    localparam int unsigned c_MAX_CYCLES = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int unsigned c_TIMER_W    = ($clog2(c_MAX_CYCLES) > 0) ? $clog2(c_MAX_CYCLES) : 1;
    localparam logic [c_TIMER_W-1:0] c_OPEN_LOAD = c_TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_LOCK_LOAD = c_TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [2:0]           c_FAIL_MAX  = 3'(MAX_FAILS);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [c_TIMER_W-1:0]   w_next_timer;
    logic [2:0]             r_fail;
    logic [2:0]             w_next_fail;
    logic [2:0]             w_fail_inc;
    logic                   w_submit;

    edge_rise u_edge_rise (
        .clk   (clk),
        .rst   (rst),
        .d     (enter),
        .pulse (w_submit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOCKED;
            r_timer <= '0;
            r_fail  <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_timer <= w_next_timer;
            r_fail  <= w_next_fail;
        end
    end

    assign w_fail_inc = r_fail + 3'd1;

    // Submits only matter in LOCKED, so an edge coinciding with an exit from
    // OPEN or LOCKOUT is dropped without extra qualification.
    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        w_next_fail  = r_fail;
        case (r_state)
            LOCKED: begin
                if (w_submit) begin
                    if (code_ok) begin
                        w_next_state = OPEN;
                        w_next_fail  = 3'd0;
                        w_next_timer = c_OPEN_LOAD;
                    end else begin
                        w_next_fail = w_fail_inc;
                        if (w_fail_inc == c_FAIL_MAX) begin
                            w_next_state = LOCKOUT;
                            w_next_timer = c_LOCK_LOAD;
                        end
                    end
                end
            end
            OPEN: begin
                if (r_timer != '0) begin
                    w_next_timer = r_timer - 1'b1;
                end else if (door_closed) begin
                    w_next_state = LOCKED;
                end
            end
            LOCKOUT: begin
                if (r_timer != '0) begin
                    w_next_timer = r_timer - 1'b1;
                end else begin
                    w_next_state = LOCKED;
                    w_next_fail  = 3'd0;
                end
            end
            default: begin
                w_next_state = LOCKED;
                w_next_timer = '0;
                w_next_fail  = 3'd0;
            end
        endcase
    end

    assign unlock   = (r_state == OPEN);
    assign alarm    = (r_state == LOCKOUT);
    assign fail_cnt = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_safe_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_safe_lock_ctrl
// Brief   : Directed self-checking bench with a cycle-count reference model.
// Revision: 1.0
// ============================================================================
module tb_safe_lock_ctrl;

    localparam int OPEN_N = 4;
    localparam int LOCK_N = 8;
    localparam int FAILS_N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enter = 1'b0;
    logic       code_ok = 1'b0;
    logic       door_closed = 1'b1;
    logic       unlock;
    logic       alarm;
    logic [2:0] fail_cnt;

    int checks = 0;
    int errors = 0;

    safe_lock_ctrl #(
        .OPEN_CYCLES (OPEN_N),
        .LOCK_CYCLES (LOCK_N),
        .MAX_FAILS   (FAILS_N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enter       (enter),
        .code_ok     (code_ok),
        .door_closed (door_closed),
        .unlock      (unlock),
        .alarm       (alarm),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: tracks how long the lock has been in its current
    // mode rather than a countdown timer.
    bit m_valid = 0;
    bit m_open = 0;
    bit m_lock = 0;
    int m_fails = 0;
    int m_elapsed = 0;
    bit m_prev = 1;

    always @(posedge clk) begin
        bit sub;
        sub = enter && !m_prev;
        m_prev = enter;
        if (rst) begin
            m_open = 0; m_lock = 0; m_fails = 0; m_elapsed = 0; m_prev = 1;
        end else if (m_open) begin
            if (m_elapsed >= OPEN_N && door_closed) m_open = 0;
            else m_elapsed++;
        end else if (m_lock) begin
            if (m_elapsed >= LOCK_N) begin m_lock = 0; m_fails = 0; end
            else m_elapsed++;
        end else if (sub) begin
            if (code_ok) begin
                m_open = 1; m_fails = 0; m_elapsed = 1;
            end else begin
                m_fails++;
                if (m_fails == FAILS_N) begin m_lock = 1; m_elapsed = 1; end
            end
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_unlock", {31'b0, unlock}, {31'b0, m_open});
            check("model_alarm", {31'b0, alarm}, {31'b0, m_lock});
            check("model_fail_cnt", {29'b0, fail_cnt}, m_fails);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // One-cycle submit; code_ok is inverted afterwards to prove it is only
    // sampled with the edge.
    task automatic pulse(input logic ok);
        @(negedge clk); #1;
        enter = 1'b1;
        code_ok = ok;
        @(negedge clk); #1;
        enter = 1'b0;
        code_ok = ~ok;
    endtask

    initial begin
        int cnt;
        step(3);
        rst = 1'b0;
        check("reset_unlock", {31'b0, unlock}, 0);
        check("reset_alarm", {31'b0, alarm}, 0);
        check("reset_fail_cnt", {29'b0, fail_cnt}, 0);

        // Valid code, door closed.
        pulse(1'b1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cnt += int'(unlock);
            step(1);
        end
        check("open_cycles", cnt, 4);
        check("open_after_fail_cnt", {29'b0, fail_cnt}, 0);

        // Three failures then lockout; submits during lockout ignored.
        pulse(1'b0); step(1);
        check("fail_1", {29'b0, fail_cnt}, 1);
        pulse(1'b0); step(1);
        check("fail_2", {29'b0, fail_cnt}, 2);
        pulse(1'b0);
        check("lockout_alarm", {31'b0, alarm}, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cnt += int'(alarm);
            if (i == 3) begin enter = 1'b1; code_ok = 1'b1; end
            if (i == 4) begin enter = 1'b0; code_ok = 1'b0; end
            step(1);
        end
        check("lockout_cycles", cnt, 8);
        check("lockout_exit_fail_cnt", {29'b0, fail_cnt}, 0);
        check("lockout_exit_unlock", {31'b0, unlock}, 0);

        // Door held open past the timer.
        door_closed = 1'b0;
        pulse(1'b1);
        step(10);
        check("door_open_hold", {31'b0, unlock}, 1);
        door_closed = 1'b1;
        step(1);
        check("door_closed_drop", {31'b0, unlock}, 0);

        // Held button, then reset with the button still held.
        code_ok = 1'b0;
        enter = 1'b1;
        step(20);
        check("held_fail_cnt", {29'b0, fail_cnt}, 1);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(5);
        check("held_reset_fail_cnt", {29'b0, fail_cnt}, 0);
        check("held_reset_unlock", {31'b0, unlock}, 0);
        enter = 1'b0;
        step(1);

        // Reset in cycle 2 of OPEN.
        pulse(1'b1);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_open_unlock", {31'b0, unlock}, 0);
        check("rst_open_fail_cnt", {29'b0, fail_cnt}, 0);
        pulse(1'b1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cnt += int'(unlock);
            step(1);
        end
        check("rst_open_reopen_cycles", cnt, 4);

        // Reset in cycle 5 of LOCKOUT.
        pulse(1'b0); step(1);
        pulse(1'b0); step(1);
        pulse(1'b0);
        step(4);
        check("rst_lock_pre_alarm", {31'b0, alarm}, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_lock_alarm", {31'b0, alarm}, 0);
        check("rst_lock_fail_cnt", {29'b0, fail_cnt}, 0);
        pulse(1'b1);
        check("rst_lock_reopen", {31'b0, unlock}, 1);
        step(6);

        // Two failures, success, then a single failure.
        pulse(1'b0); step(1);
        pulse(1'b0); step(1);
        pulse(1'b1);
        check("recover_fail_cnt", {29'b0, fail_cnt}, 0);
        check("recover_unlock", {31'b0, unlock}, 1);
        step(6);
        pulse(1'b0); step(1);
        check("recover_refail_cnt", {29'b0, fail_cnt}, 1);
        check("recover_refail_alarm", {31'b0, alarm}, 0);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
